// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, 32x32 register file with write-through,
// load-use hazard detection and fetch redirect control for JMP/JR.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [1:0]  pc_mode,
  output logic [31:0] reg_target,
  output logic [31:0] imm_target,
  output logic        id_valid,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic [31:0] id_rs1_val,
  output logic [31:0] id_rs2_val,
  output logic [31:0] id_imm
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned OPW  = 6;
  localparam int unsigned IMMW = 16;

  localparam logic [OPW-1:0] OP_NOP   = 6'h00;
  localparam logic [OPW-1:0] OP_ALU   = 6'h01;
  localparam logic [OPW-1:0] OP_ALUI  = 6'h02;
  localparam logic [OPW-1:0] OP_LOAD  = 6'h03;
  localparam logic [OPW-1:0] OP_STORE = 6'h04;
  localparam logic [OPW-1:0] OP_JMP   = 6'h05;
  localparam logic [OPW-1:0] OP_JR    = 6'h06;

  localparam logic [1:0] PC_STALL  = 2'b00;
  localparam logic [1:0] PC_NORMAL = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_IMM    = 2'b11;

  logic [XLEN-1:0] if_id_instr;
  logic            if_id_valid;
  logic [XLEN-1:0] regs [NREG];
  logic            ex_load;
  logic [AW-1:0]   ex_rd;

  logic [OPW-1:0]  raw_op;
  logic [OPW-1:0]  op;
  logic [AW-1:0]   rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [IMMW-1:0] imm16;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            load_use_hazard;
  logic            issue;
  logic            redirect;

  assign raw_op   = if_id_instr[31:26];
  assign rd       = if_id_instr[25:21];
  assign rs1      = if_id_instr[20:16];
  assign rs2      = if_id_instr[15:11];
  assign imm16    = if_id_instr[15:0];
  assign imm_sext = {{(XLEN-IMMW){imm16[IMMW-1]}}, imm16};

  // Unknown opcodes collapse to NOP so they never read sources or redirect.
  always_comb begin
    op = OP_NOP;
    case (raw_op)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_JMP, OP_JR: op = raw_op;
      default: op = OP_NOP;
    endcase
  end

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (op)
      OP_ALU, OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_ALUI, OP_LOAD, OP_JR: uses_rs1 = 1'b1;
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // Read ports: r0 hardwired to zero, same-cycle writeback bypasses the array.
  always_comb begin
    rs1_val = regs[rs1];
    if (rs1 == AW'(0))
      rs1_val = '0;
    else if (wb_en && (wb_addr == rs1))
      rs1_val = wb_data;
  end

  always_comb begin
    rs2_val = regs[rs2];
    if (rs2 == AW'(0))
      rs2_val = '0;
    else if (wb_en && (wb_addr == rs2))
      rs2_val = wb_data;
  end

  // A load in execute cannot forward yet; hold the consumer one cycle.
  always_comb begin
    load_use_hazard = 1'b0;
    if (if_id_valid && ex_load && (ex_rd != AW'(0))) begin
      if ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)))
        load_use_hazard = 1'b1;
    end
  end

  assign issue    = if_id_valid && !load_use_hazard;
  assign redirect = issue && ((op == OP_JMP) || (op == OP_JR));

  always_comb begin
    pc_mode = PC_NORMAL;
    if (load_use_hazard)
      pc_mode = PC_STALL;
    else if (issue && (op == OP_JMP))
      pc_mode = PC_IMM;
    else if (issue && (op == OP_JR))
      pc_mode = PC_REG;
  end

  assign id_valid   = issue;
  assign id_opcode  = op;
  assign id_rd      = rd;
  assign id_rs1_val = rs1_val;
  assign id_rs2_val = rs2_val;
  assign id_imm     = imm_sext;
  assign imm_target = imm_sext;
  assign reg_target = rs1_val;

  // IF/ID: hold on hazard, capture as a squashed slot after a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (!load_use_hazard) begin
      if_id_instr <= if_instr;
      if_id_valid <= !redirect;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_load <= 1'b0;
      ex_rd   <= '0;
    end else begin
      ex_load <= issue && (op == OP_LOAD);
      ex_rd   <= (issue && (op == OP_LOAD)) ? rd : AW'(0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_en && (wb_addr != AW'(0))) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule
